// File: rtl/ea_calc.sv
// ea_calc: effective-address calculator for a 36-bit word machine.
// Latches an instruction word, optionally adds an index accumulator to Y,
// and follows indirect words through memory until a direct word yields
// the final address. Runaway indirect chains are cut off with a fault.
module ea_calc #(
  parameter int MAX_IND = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         start,
  input  logic [0:35]  instr,
  input  logic         abort,
  output logic         acReq,
  output logic [3:0]   acAddr,
  input  logic         acAck,
  input  logic [0:35]  acData,
  output logic         memReq,
  output logic [18:35] memAddr,
  input  logic         memAck,
  input  logic [0:35]  memData,
  output logic [18:35] EA,
  output logic         done,
  output logic         fault,
  output logic         busy
);

  localparam int               CNT_W   = $clog2(MAX_IND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IND);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XREAD = 2'd1,
    ST_IREAD = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  state_e             state_r;
  state_e             state_nx_s;
  logic [13:35]       w_r;
  logic [13:35]       w_nx_s;
  logic [18:35]       e_r;
  logic [18:35]       e_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic [18:35]       ea_r;
  logic [18:35]       ea_nx_s;
  logic               done_r;
  logic               done_nx_s;
  logic               fault_r;
  logic               fault_nx_s;
  logic               busy_r;
  logic               ac_req_r;
  logic               mem_req_r;

  // Only the I/X/Y fields of the incoming words matter; the left halves are don't-care.
  logic               unused_s;
  assign unused_s = ^{instr[0:12], acData[0:17], memData[0:12]};

  // Where a freshly latched word goes next: index first, then indirection, else finish.
  function automatic state_e route_word(input logic ind, input logic [3:0] idx);
    state_e nx;
    if (idx != 4'd0) begin
      nx = ST_XREAD;
    end else if (ind) begin
      nx = ST_IREAD;
    end else begin
      nx = ST_FIN;
    end
    return nx;
  endfunction

  // Next-state and datapath decisions for one clock.
  always_comb begin
    state_nx_s = state_r;
    w_nx_s     = w_r;
    e_nx_s     = e_r;
    cnt_nx_s   = cnt_r;
    ea_nx_s    = ea_r;
    done_nx_s  = 1'b0;
    fault_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          w_nx_s     = instr[13:35];
          e_nx_s     = instr[18:35];
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = route_word(instr[13], instr[14:17]);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_XREAD: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (acAck) begin
          e_nx_s     = w_r[18:35] + acData[18:35];
          state_nx_s = w_r[13] ? ST_IREAD : ST_FIN;
        end else begin
          state_nx_s = ST_XREAD;
        end
      end
      ST_IREAD: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (memAck) begin
          w_nx_s     = memData[13:35];
          e_nx_s     = memData[18:35];
          cnt_nx_s   = cnt_r + CNT_ONE;
          state_nx_s = route_word(memData[13], memData[14:17]);
        end else begin
          state_nx_s = ST_IREAD;
        end
      end
      ST_FIN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          ea_nx_s    = e_r;
          done_nx_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    // After MAX_IND fetches another one would push the count past the limit,
    // so the chain faults instead of issuing it.
    if ((state_nx_s == ST_IREAD) && (cnt_nx_s >= CNT_MAX)) begin
      state_nx_s = ST_IDLE;
      fault_nx_s = 1'b1;
    end else begin
      fault_nx_s = 1'b0;
    end
  end

  // State, datapath and all outputs registered together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r   <= ST_IDLE;
      w_r       <= 23'd0;
      e_r       <= 18'd0;
      cnt_r     <= {CNT_W{1'b0}};
      ea_r      <= 18'd0;
      done_r    <= 1'b0;
      fault_r   <= 1'b0;
      busy_r    <= 1'b0;
      ac_req_r  <= 1'b0;
      mem_req_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      w_r       <= w_nx_s;
      e_r       <= e_nx_s;
      cnt_r     <= cnt_nx_s;
      ea_r      <= ea_nx_s;
      done_r    <= done_nx_s;
      fault_r   <= fault_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
      ac_req_r  <= (state_nx_s == ST_XREAD);
      mem_req_r <= (state_nx_s == ST_IREAD);
    end
  end

  assign acReq   = ac_req_r;
  assign acAddr  = w_r[14:17];
  assign memReq  = mem_req_r;
  assign memAddr = e_r;
  assign EA      = ea_r;
  assign done    = done_r;
  assign fault   = fault_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_ea_calc.sv
// Bench for ea_calc: random instructions, accumulators and memory contents
// checked against a direct walk of the addressing rules.
module tb_ea_calc;

  localparam int MAX_IND = 16;

  logic         clk = 1'b0;
  logic         resetN, start, abort, acAck, memAck;
  logic [0:35]  instr, acData, memData;
  logic         acReq, memReq, done, fault, busy;
  logic [3:0]   acAddr;
  logic [18:35] memAddr, EA;

  int n_vec = 0;
  int n_err = 0;

  logic [0:35] ac [16];
  logic [0:35] mem [logic [17:0]];
  logic [17:0] exp_mem_q [$];
  logic [3:0]  exp_ac_q [$];
  logic [17:0] last_ea;

  ea_calc #(.MAX_IND(MAX_IND)) dut (
    .clk(clk), .resetN(resetN), .start(start), .instr(instr), .abort(abort),
    .acReq(acReq), .acAddr(acAddr), .acAck(acAck), .acData(acData),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
    .EA(EA), .done(done), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [0:35] rnd36();
    logic [0:35] v;
    v = {4'($urandom), 32'($urandom)};
    return v;
  endfunction

  function automatic logic [0:35] mem_word(input logic [17:0] a);
    if (!mem.exists(a)) mem[a] = rnd36();
    return mem[a];
  endfunction

  function automatic logic [0:35] mk_word(input logic i, input logic [3:0] x, input logic [17:0] y);
    logic [0:35] v;
    v = {13'($urandom), i, x, y};
    return v;
  endfunction

  // Walk the addressing rules directly; records expected AC and memory addresses.
  function automatic void model(input logic [0:35] ins, output bit ef, output logic [17:0] eea, output int nfetch);
    logic [0:35] wd;
    logic [17:0] e;
    logic [3:0]  x;
    bit          fin;
    int          n;
    exp_mem_q.delete();
    exp_ac_q.delete();
    wd = ins; n = 0; fin = 1'b0; ef = 1'b0; eea = last_ea;
    while (!fin) begin
      x = wd[14:17];
      e = wd[18:35];
      if (x != 4'd0) begin
        exp_ac_q.push_back(x);
        e = e + ac[x][18:35];
      end
      if (!wd[13]) begin
        eea = e; fin = 1'b1;
      end else if (n == MAX_IND) begin
        ef = 1'b1; fin = 1'b1;
      end else begin
        n++;
        exp_mem_q.push_back(e);
        wd = mem_word(e);
      end
    end
    nfetch = n;
  endfunction

  task automatic rand_ac();
    for (int k = 0; k < 16; k++) ac[k] = rnd36();
  endtask

  // Runs one calculation, answering AC and memory requests from the bench's arrays.
  task automatic drive_calc(input logic [0:35] ins, input int dmin, input int dmax, input bit noise,
                            output int nd, output int nf, output int nm, output int na,
                            output int nb, output int lat, output int nt, output logic [17:0] ea_seen);
    int aw, mw;
    bit fin;
    nd = 0; nf = 0; nm = 0; na = 0; nb = 0; nt = 0; lat = -1; fin = 1'b0;
    @(negedge clk);
    instr = ins; start = 1'b1; abort = 1'b0; acAck = 1'b0; memAck = 1'b0;
    @(negedge clk);
    start = 1'b0; instr = rnd36();
    aw = $urandom_range(dmax, dmin);
    mw = $urandom_range(dmax, dmin);
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      if (done) begin nd++; fin = 1'b1; lat = cyc; end
      if (fault) begin nf++; fin = 1'b1; lat = cyc; end
      if (acReq && memReq) nb++;
      acAck = 1'b0; memAck = 1'b0; start = 1'b0;
      if (acReq) begin
        if (exp_ac_q.size() == 0 || acAddr !== exp_ac_q[0]) nb++;
        if (aw == 0) begin
          acAck = 1'b1; acData = ac[acAddr]; na++;
          aw = $urandom_range(dmax, dmin);
          if (exp_ac_q.size() != 0) void'(exp_ac_q.pop_front());
        end else aw--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        acAck = 1'b1; acData = rnd36();
      end
      if (memReq) begin
        if (exp_mem_q.size() == 0 || memAddr !== exp_mem_q[0]) nb++;
        if (mw == 0) begin
          memAck = 1'b1; memData = mem_word(memAddr); nm++;
          mw = $urandom_range(dmax, dmin);
          if (exp_mem_q.size() != 0) void'(exp_mem_q.pop_front());
        end else mw--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        memAck = 1'b1; memData = rnd36();
      end
      if (noise && !fin && busy && $urandom_range(3, 0) == 0) begin
        start = 1'b1; instr = rnd36();
      end
      @(negedge clk);
    end
    acAck = 1'b0; memAck = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (done || fault || busy || acReq || memReq) nt++;
      @(negedge clk);
    end
    ea_seen = EA;
    if (busy) begin
      abort = 1'b1; @(negedge clk); abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; start = 1'b0; abort = 1'b0; acAck = 1'b0; memAck = 1'b0;
    instr = 36'd0; acData = 36'd0; memData = 36'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({acReq, memReq, done, fault, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 00000", {acReq, memReq, done, fault, busy});
    end
    n_vec++;
    if (EA !== 18'd0) begin n_err++; $display("FAIL reset_ea: got %o want 0", EA); end
    resetN = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    last_ea = 18'd0;
  endtask

  task automatic test_simple();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas; logic [0:35] ins;
    rand_ac();
    ins = mk_word(1'b0, 4'd0, 18'o001234);
    model(ins, ef, eea, en);
    drive_calc(ins, 0, 0, 1'b0, nd, nf, nm, na, nb, lat, nt, eas);
    n_vec++;
    if (nd != 1 || nf != 0) begin n_err++; $display("FAIL simple_outcome: got done=%0d fault=%0d want 1/0", nd, nf); end
    n_vec++;
    if (lat != 2) begin n_err++; $display("FAIL simple_latency: got %0d want 2", lat); end
    n_vec++;
    if (eas !== 18'o001234) begin n_err++; $display("FAIL simple_ea: got %o want 001234", eas); end
    n_vec++;
    if (na != 0 || nm != 0) begin n_err++; $display("FAIL simple_no_reads: got ac=%0d mem=%0d want 0/0", na, nm); end
    n_vec++;
    if (nt != 0) begin n_err++; $display("FAIL simple_tail: got %0d stray cycles want 0", nt); end
    last_ea = 18'o001234;
  endtask

  task automatic test_index_wrap();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas; logic [0:35] ins;
    rand_ac();
    ac[3] = {18'($urandom), 18'o000020};
    ins = mk_word(1'b0, 4'd3, 18'o777770);
    model(ins, ef, eea, en);
    drive_calc(ins, 2, 2, 1'b0, nd, nf, nm, na, nb, lat, nt, eas);
    n_vec++;
    if (eas !== 18'o000010) begin n_err++; $display("FAIL wrap_ea: got %o want 000010", eas); end
    n_vec++;
    if (na != 1 || nm != 0 || nd != 1) begin
      n_err++; $display("FAIL wrap_counts: got ac=%0d mem=%0d done=%0d want 1/0/1", na, nm, nd);
    end
    n_vec++;
    if (nb != 0) begin n_err++; $display("FAIL wrap_acaddr: got %0d bad request cycles want 0", nb); end
    n_vec++;
    if (lat != 5) begin n_err++; $display("FAIL wrap_latency: got %0d want 5", lat); end
    last_ea = 18'o000010;
  endtask

  task automatic test_indirect();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas; logic [0:35] ins;
    rand_ac();
    mem[18'o000100] = mk_word(1'b0, 4'd0, 18'o005000);
    ins = mk_word(1'b1, 4'd0, 18'o000100);
    model(ins, ef, eea, en);
    drive_calc(ins, 0, 3, 1'b1, nd, nf, nm, na, nb, lat, nt, eas);
    n_vec++;
    if (eas !== 18'o005000) begin n_err++; $display("FAIL indirect_ea: got %o want 005000", eas); end
    n_vec++;
    if (nm != 1 || na != 0 || nd != 1) begin
      n_err++; $display("FAIL indirect_counts: got mem=%0d ac=%0d done=%0d want 1/0/1", nm, na, nd);
    end
    n_vec++;
    if (nb != 0) begin n_err++; $display("FAIL indirect_memaddr: got %0d bad request cycles want 0", nb); end
    last_ea = 18'o005000;
  endtask

  task automatic test_chain_fault();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas, a; logic [0:35] ins;
    rand_ac();
    a = 18'($urandom);
    mem[a] = {13'd0, 1'b1, 4'd0, a};
    ins = mk_word(1'b1, 4'd0, a);
    model(ins, ef, eea, en);
    drive_calc(ins, 0, 2, 1'b1, nd, nf, nm, na, nb, lat, nt, eas);
    n_vec++;
    if (nf != 1 || nd != 0) begin n_err++; $display("FAIL chain_outcome: got fault=%0d done=%0d want 1/0", nf, nd); end
    n_vec++;
    if (nm != MAX_IND) begin n_err++; $display("FAIL chain_fetches: got %0d want %0d", nm, MAX_IND); end
    n_vec++;
    if (nt != 0 || nb != 0) begin n_err++; $display("FAIL chain_after: got tail=%0d bad=%0d want 0/0", nt, nb); end
    n_vec++;
    if (eas !== last_ea) begin n_err++; $display("FAIL chain_ea_hold: got %o want %o", eas, last_ea); end
  endtask

  task automatic test_abort();
    logic [17:0] a; logic [0:35] ins; int pulses;
    a = 18'($urandom);
    mem[a] = mk_word(1'b0, 4'd0, 18'($urandom));
    ins = mk_word(1'b1, 4'd0, a);
    @(negedge clk); instr = ins; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && memReq !== 1'b1; k++) @(negedge clk);
    n_vec++;
    if (memReq !== 1'b1) begin n_err++; $display("FAIL abort_memreq_seen: got %b want 1", memReq); end
    abort = 1'b1; memAck = 1'b1; memData = mem[a];
    @(negedge clk); abort = 1'b0; memAck = 1'b0;
    n_vec++;
    if ({memReq, busy, done, fault} !== 4'b0) begin
      n_err++; $display("FAIL abort_mem_next: got %b want 0000", {memReq, busy, done, fault});
    end
    pulses = 0;
    repeat (3) begin if (done || fault) pulses++; @(negedge clk); end
    n_vec++;
    if (pulses != 0 || EA !== last_ea) begin
      n_err++; $display("FAIL abort_mem_quiet: got pulses=%0d ea=%o want 0/%o", pulses, EA, last_ea);
    end
    ins = mk_word(1'b0, 4'd5, 18'($urandom));
    @(negedge clk); instr = ins; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && acReq !== 1'b1; k++) @(negedge clk);
    abort = 1'b1; acAck = 1'b1; acData = rnd36();
    @(negedge clk); abort = 1'b0; acAck = 1'b0;
    n_vec++;
    if ({acReq, busy, done} !== 3'b0 || EA !== last_ea) begin
      n_err++; $display("FAIL abort_ac_next: got req/busy/done=%b ea=%o want 000/%o", {acReq, busy, done}, EA, last_ea);
    end
  endtask

  task automatic test_abort_start_idle();
    logic [17:0] y;
    y = 18'($urandom);
    @(negedge clk); instr = mk_word(1'b0, 4'd0, y); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || EA !== y) begin
      n_err++; $display("FAIL start_abort_idle: got done=%b ea=%o want 1/%o", done, EA, y);
    end
    last_ea = y;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas, y; logic [0:35] ins;
    @(negedge clk); instr = mk_word(1'b0, 4'd3, 18'($urandom)); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && acReq !== 1'b1; k++) @(negedge clk);
    n_vec++;
    if (acReq !== 1'b1) begin n_err++; $display("FAIL rstmid_acreq_seen: got %b want 1", acReq); end
    #2 resetN = 1'b0;
    #1;
    n_vec++;
    if ({acReq, busy} !== 2'b0 || EA !== 18'd0) begin
      n_err++; $display("FAIL rstmid_async: got req/busy=%b ea=%o want 00/0", {acReq, busy}, EA);
    end
    @(negedge clk); resetN = 1'b1;
    last_ea = 18'd0;
    y = 18'($urandom);
    ins = mk_word(1'b0, 4'd0, y);
    model(ins, ef, eea, en);
    drive_calc(ins, 0, 1, 1'b0, nd, nf, nm, na, nb, lat, nt, eas);
    n_vec++;
    if (nd != 1 || eas !== y) begin n_err++; $display("FAIL rstmid_recover: got done=%0d ea=%o want 1/%o", nd, eas, y); end
    last_ea = y;
  endtask

  task automatic test_random();
    int nd, nf, nm, na, nb, lat, nt, en; bit ef; logic [17:0] eea, eas, y, want; logic [0:35] ins; logic [3:0] x;
    for (int t = 0; t < 60; t++) begin
      rand_ac();
      y = 18'($urandom);
      x = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(7, 0) == 0) mem[y] = {13'd0, 1'b1, 4'd0, y};
      ins = mk_word(1'($urandom), x, y);
      model(ins, ef, eea, en);
      drive_calc(ins, 0, 3, 1'b1, nd, nf, nm, na, nb, lat, nt, eas);
      want = ef ? last_ea : eea;
      n_vec++;
      if (nd != (ef ? 0 : 1) || nf != (ef ? 1 : 0)) begin
        n_err++; $display("FAIL rand%0d_outcome: got done=%0d fault=%0d want fault=%0d", t, nd, nf, ef);
      end
      n_vec++;
      if (eas !== want) begin n_err++; $display("FAIL rand%0d_ea: got %o want %o", t, eas, want); end
      n_vec++;
      if (nm != en || nb != 0 || nt != 0) begin
        n_err++; $display("FAIL rand%0d_protocol: got mem=%0d bad=%0d tail=%0d want %0d/0/0", t, nm, nb, nt, en);
      end
      last_ea = want;
    end
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; abort = 1'b0; acAck = 1'b0; memAck = 1'b0;
    instr = 36'd0; acData = 36'd0; memData = 36'd0; last_ea = 18'd0;
    test_reset();
    test_simple();
    test_index_wrap();
    test_indirect();
    test_chain_fault();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
